// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op-codes, FSM states, width helper.
// No logic of its own; imported by alu_mc and shift_add_mul.
// Operand/result width is always twice the half-operand width.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  // Full operand/result width derived from the half-operand width.
  function automatic int calc_w(input int part_len);
    return 2 * part_len;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier over PART_LEN-bit operands, W-bit exact product.
// Latency: PART_LEN/MUL_BITS_PER_CYC cycles after start; done_o flags the final cycle.
// No backpressure: the caller starts it only when idle and samples product_o on done_o.
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int PART_LEN         = 8,
  parameter int MUL_BITS_PER_CYC = 1,
  localparam int W               = calc_w(PART_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [PART_LEN-1:0] mcand_i,
  input  logic [PART_LEN-1:0] mplier_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [W-1:0]        product_o
);

  // MUL_BITS_PER_CYC must divide PART_LEN so the last step retires the top bits exactly.
  localparam int STEPS = PART_LEN / MUL_BITS_PER_CYC;
  localparam int CW    = $clog2(STEPS + 1);

  logic                busy_q;
  logic [CW-1:0]       cnt_q;
  logic [W-1:0]        acc_q;
  logic [W-1:0]        mcand_q;
  logic [PART_LEN-1:0] mplier_q;
  logic [W-1:0]        partial_d;
  logic [W-1:0]        acc_d;

  // Sum of the multiplicand copies selected by the multiplier bits retired this cycle.
  always_comb begin
    partial_d = '0;
    for (int j = 0; j < MUL_BITS_PER_CYC; j++) begin
      if (mplier_q[j]) partial_d = partial_d + (mcand_q << j);
    end
  end

  assign acc_d     = acc_q + partial_d;
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == '0);
  // Exposes the post-step accumulator so the caller can register it on the done cycle.
  assign product_o = acc_d;

  // Load on start, then shift multiplicand up / multiplier down and accumulate each step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(STEPS - 1);
      acc_q    <= '0;
      mcand_q  <= {{PART_LEN{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_BITS_PER_CYC;
      mplier_q <= mplier_q >> MUL_BITS_PER_CYC;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: ADD/SUB with carry/overflow/zero flags, iterative MUL, illegal-op error.
// Latency: 1 cycle for ADD/SUB/illegal, 1 + PART_LEN/MUL_BITS_PER_CYC cycles for MUL.
// Backpressure: result and flags held in DONE until out_ready; in_ready low whenever not IDLE.
module alu_mc
  import alu_pkg::*;
#(
  parameter int PART_LEN         = 8,
  parameter int MUL_BITS_PER_CYC = 1,
  localparam int W               = calc_w(PART_LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         err
);

  state_e         state_q;
  logic [W-1:0]   res_q;
  logic           carry_q, ovf_q, zero_q, err_q, out_valid_q;

  logic           accept;
  logic           mul_start, mul_busy, mul_done;
  logic [W-1:0]   mul_prod;
  logic [W:0]     sum_d, diff_d;
  logic           add_ovf_d, sub_ovf_d;

  assign in_ready  = (state_q == S_IDLE) && !rst && !mul_busy;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  // One extra bit holds the ADD carry-out / SUB borrow (borrow == unsigned a < b).
  assign sum_d     = {1'b0, a} + {1'b0, b};
  assign diff_d    = {1'b0, a} - {1'b0, b};
  assign add_ovf_d = (a[W-1] == b[W-1]) && (sum_d[W-1]  != a[W-1]);
  assign sub_ovf_d = (a[W-1] != b[W-1]) && (diff_d[W-1] != a[W-1]);

  shift_add_mul #(
    .PART_LEN        (PART_LEN),
    .MUL_BITS_PER_CYC(MUL_BITS_PER_CYC)
  ) u_mul (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (mul_start),
    .mcand_i  (a[PART_LEN-1:0]),
    .mplier_i (b[PART_LEN-1:0]),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  // Control FSM; result and flags are registered together so they always match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      res_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_ADD: begin
                res_q       <= sum_d[W-1:0];
                carry_q     <= sum_d[W];
                ovf_q       <= add_ovf_d;
                zero_q      <= (sum_d[W-1:0] == '0);
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
              OP_SUB: begin
                res_q       <= diff_d[W-1:0];
                carry_q     <= diff_d[W];
                ovf_q       <= sub_ovf_d;
                zero_q      <= (diff_d[W-1:0] == '0);
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
              OP_MUL: begin
                state_q <= S_MUL_RUN;
              end
              default: begin
                res_q       <= '0;
                carry_q     <= 1'b0;
                ovf_q       <= 1'b0;
                zero_q      <= 1'b1;
                err_q       <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end
        end
        S_MUL_RUN: begin
          if (mul_done) begin
            res_q       <= mul_prod;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (mul_prod == '0);
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res       = res_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: default instance (1 bit/cycle) and a 2 bits/cycle instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic        out_ready = 1'b1, out_ready2 = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, carry, ovf, zero, err;
  logic [15:0] res;
  logic        in_ready2, out_valid2, carry2, ovf2, zero2, err2;
  logic [15:0] res2;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  alu_mc #(.PART_LEN(8), .MUL_BITS_PER_CYC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .carry(carry), .ovf(ovf),
    .zero(zero), .err(err)
  );

  alu_mc #(.PART_LEN(8), .MUL_BITS_PER_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .op(op), .a(a), .b(b),
    .out_valid(out_valid2), .out_ready(out_ready2), .res(res2), .carry(carry2), .ovf(ovf2),
    .zero(zero2), .err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one op to dut, then wait (bounded) for out_valid; lat counts cycles after accept.
  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int l);
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_flags", {carry, ovf, zero, err}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // ADD 0xFFFF + 0x0001
    issue(OP_ADD, 16'hFFFF, 16'h0001, lat);
    chk("add_lat", lat, 1);
    chk("add_res", res, 16'h0000);
    chk("add_flags_c_o_z_e", {carry, ovf, zero, err}, 4'b1010);
    step();
    chk("add_release_out_valid", out_valid, 0);
    chk("add_release_in_ready", in_ready, 1);

    // SUB 0x8000 - 0x0001
    issue(OP_SUB, 16'h8000, 16'h0001, lat);
    chk("sub1_lat", lat, 1);
    chk("sub1_res", res, 16'h7FFF);
    chk("sub1_flags_c_o_z_e", {carry, ovf, zero, err}, 4'b0100);
    step();

    // SUB 0x0003 - 0x0005
    issue(OP_SUB, 16'h0003, 16'h0005, lat);
    chk("sub2_res", res, 16'hFFFE);
    chk("sub2_flags_c_o_z_e", {carry, ovf, zero, err}, 4'b1000);
    step();

    // MUL, upper bytes ignored: 0xFF * 0xFF
    issue(OP_MUL, 16'h12FF, 16'h34FF, lat);
    chk("mul_lat", lat, 9);
    chk("mul_res", res, 16'hFE01);
    chk("mul_flags_c_o_z_e", {carry, ovf, zero, err}, 4'b0000);
    step();

    // MUL 0x80 * 0x02
    issue(OP_MUL, 16'hFF80, 16'h0102, lat);
    chk("mul2_res", res, 16'h0100);
    step();

    // MUL with zero multiplier
    issue(OP_MUL, 16'h00AB, 16'h7700, lat);
    chk("mul_zero_res", res, 16'h0000);
    chk("mul_zero_flag", zero, 1);
    step();

    // Two bits per cycle instance: same MUL, latency 5
    op = OP_MUL; a = 16'h12FF; b = 16'h34FF; in_valid2 = 1'b1;
    #1;
    chk("mul2b_in_ready", in_ready2, 1);
    step();
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 40) begin
      step();
      lat++;
    end
    chk("mul2b_lat", lat, 5);
    chk("mul2b_res", res2, 16'hFE01);
    step();

    // Backpressure: result held, competing request ignored
    out_ready = 1'b0;
    issue(OP_ADD, 16'h1234, 16'h1111, lat);
    chk("bp_lat", lat, 1);
    op = OP_SUB; a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_res", res, 16'h2345);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_still_res", res, 16'h2345);
    step();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // Reset during the 4th MUL_RUN cycle
    op = OP_MUL; a = 16'h00FF; b = 16'h00FF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_res", res, 0);
    chk("midrst_flags", {carry, ovf, zero, err}, 0);
    chk("midrst_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_never_valid", seen, 0);
    issue(OP_ADD, 16'h0002, 16'h0003, lat);
    chk("postrst_add_lat", lat, 1);
    chk("postrst_add_res", res, 16'h0005);
    step();

    // Illegal op, then a legal op clears err
    issue(OP_ILL, 16'hAAAA, 16'h5555, lat);
    chk("ill_lat", lat, 1);
    chk("ill_res", res, 16'h0000);
    chk("ill_flags_c_o_z_e", {carry, ovf, zero, err}, 4'b0011);
    step();
    issue(OP_ADD, 16'h0001, 16'h0001, lat);
    chk("after_ill_res", res, 16'h0002);
    chk("after_ill_flags_c_o_z_e", {carry, ovf, zero, err}, 4'b0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
